// File: rtl/logic_gate_pkg.sv
// Shared types for the pipelined multi-input gate unit.
// Op codes, base-reduction selector and decode helpers.
package logic_gate_pkg;

  localparam int LG_OP_W = 3;

  typedef enum logic [LG_OP_W-1:0] {
    LG_AND  = 3'b000,
    LG_OR   = 3'b001,
    LG_XOR  = 3'b010,
    LG_NAND = 3'b011,
    LG_NOR  = 3'b100,
    LG_XNOR = 3'b101,
    LG_PASS = 3'b110,
    LG_RSV  = 3'b111
  } lg_op_e;

  typedef enum logic [1:0] {
    LG_B_AND  = 2'b00,
    LG_B_OR   = 2'b01,
    LG_B_XOR  = 2'b10,
    LG_B_PASS = 2'b11
  } lg_base_e;

  function automatic logic lg_is_inverted(input lg_op_e op);
    logic inv;
    unique case (op)
      LG_NAND, LG_NOR, LG_XNOR: inv = 1'b1;
      default:                  inv = 1'b0;
    endcase
    return inv;
  endfunction

  // Inverted ops reuse the reduction of their positive twin.
  function automatic lg_base_e lg_base_of(input lg_op_e op);
    lg_base_e b;
    unique case (op)
      LG_AND, LG_NAND: b = LG_B_AND;
      LG_OR,  LG_NOR:  b = LG_B_OR;
      LG_XOR, LG_XNOR: b = LG_B_XOR;
      default:         b = LG_B_PASS;
    endcase
    return b;
  endfunction

  function automatic logic lg_is_rsv(input lg_op_e op);
    return op == LG_RSV;
  endfunction

endpackage

// File: rtl/logic_gate_pipe_reduce.sv
// Combinational bitwise reduction of N_IN operands (gate_reduce).
// Selects AND / OR / XOR parity / operand-0 pass-through.
module gate_reduce
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
) (
  input  logic [N_IN*WIDTH-1:0] data,
  input  lg_base_e              sel,
  output logic [WIDTH-1:0]      red
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;
  logic [WIDTH-1:0] pass_r;

  assign pass_r = data[WIDTH-1:0];

  always_comb begin
    and_r = data[WIDTH-1:0];
    or_r  = data[WIDTH-1:0];
    xor_r = data[WIDTH-1:0];
    for (int i = 1; i < N_IN; i++) begin
      and_r = and_r & data[i*WIDTH +: WIDTH];
      or_r  = or_r  | data[i*WIDTH +: WIDTH];
      xor_r = xor_r ^ data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    red = '0;
    unique case (sel)
      LG_B_AND:  red = and_r;
      LG_B_OR:   red = or_r;
      LG_B_XOR:  red = xor_r;
      LG_B_PASS: red = pass_r;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready pipelined N_IN x WIDTH bitwise gate unit.
// Define LGU_PARITY_EN to add the registered out_par output.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LG_OP_W-1:0]    in_op,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_err
`ifdef LGU_PARITY_EN
  ,
  output logic                  out_par
`endif
);

  lg_op_e           op;
  lg_base_e         base;
  logic [WIDTH-1:0] red;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_inv;
  logic             s1_err;

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] s2_data;

  assign op   = lg_op_e'(in_op);
  assign base = lg_base_of(op);

  gate_reduce #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_reduce (
    .data (in_data),
    .sel  (base),
    .red  (red)
  );

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Reserved code wins over the invert flag.
  assign s2_data = s1_err ? '0
                 : (s1_inv ? ~s1_data : s1_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_inv   <= 1'b0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_data  <= red;
      s1_inv   <= lg_is_inverted(op);
      s1_err   <= lg_is_rsv(op);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data  <= s2_data;
      out_err   <= s1_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LGU_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (s2_load) begin
      out_par <= s1_err ? 1'b0 : ^s2_data;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed-vector bench for logic_gate_pipe (narrow 1x2 and wide 8x4).
// Parity checks are compiled in when LGU_PARITY_EN is defined.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Narrow instance: WIDTH=1, N_IN=2
  logic       n_valid = 1'b0;
  logic       n_ready;
  logic [2:0] n_op = 3'b000;
  logic [1:0] n_data = '0;
  logic       n_ovalid;
  logic       n_oready = 1'b1;
  logic [0:0] n_odata;
  logic       n_oerr;
`ifdef LGU_PARITY_EN
  logic       n_opar;
`endif

  logic_gate_pipe #(.WIDTH(1), .N_IN(2)) u_narrow (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (n_valid),
    .in_ready  (n_ready),
    .in_op     (n_op),
    .in_data   (n_data),
    .out_valid (n_ovalid),
    .out_ready (n_oready),
    .out_data  (n_odata),
    .out_err   (n_oerr)
`ifdef LGU_PARITY_EN
    ,
    .out_par   (n_opar)
`endif
  );

  // Wide instance: WIDTH=8, N_IN=4
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_err;
`ifdef LGU_PARITY_EN
  logic        out_par;
`endif

  logic_gate_pipe #(.WIDTH(8), .N_IN(4)) u_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef LGU_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  // Operands 0xF0, 0x3C, 0xFF, 0x0F (operand 0 in the low byte).
  localparam logic [31:0] OPS = 32'h0FFF_3CF0;

  task automatic send_one(input string tag,
                          input logic [2:0] op,
                          input logic [31:0] d,
                          input logic [7:0] exp,
                          input logic exp_err);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(out_valid), 64'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_vld"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_data"}, 64'(out_data), 64'(exp));
    chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
`ifdef LGU_PARITY_EN
    chk({tag, "_par"}, 64'(out_par),
        64'(exp_err ? 1'b0 : ^exp));
`endif
  endtask

  logic [1:0]  nv [4];
  logic        ne [4];
  logic [31:0] bp_in [3];
  logic [7:0]  bp_exp [3];
  int          idx;
  int          ndr;

  initial begin
    nv[0] = 2'b00; nv[1] = 2'b10;
    nv[2] = 2'b01; nv[3] = 2'b11;
    ne[0] = 1'b0;  ne[1] = 1'b1;
    ne[2] = 1'b1;  ne[3] = 1'b1;
    bp_in[0] = 32'hAAAA_AA11; bp_exp[0] = 8'h11;
    bp_in[1] = 32'h5555_5522; bp_exp[1] = 8'h22;
    bp_in[2] = 32'hFFFF_FF33; bp_exp[2] = 8'h33;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ovalid", 64'(out_valid), 64'(1'b0));
    chk("rst_odata", 64'(out_data), 64'(8'h00));
    chk("rst_oerr", 64'(out_err), 64'(1'b0));
    chk("rst_iready", 64'(in_ready), 64'(1'b1));
    chk("rst_n_ready", 64'(n_ready), 64'(1'b1));
`ifdef LGU_PARITY_EN
    chk("rst_par", 64'(out_par), 64'(1'b0));
`endif

    // Narrow OR stream, back to back, 2-cycle latency
    n_op = 3'b001;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_valid = (k < 4);
      if (k < 4) n_data = nv[k];
      @(negedge clk);
      if (k < 4)
        chk("n_rdy", 64'(n_ready), 64'(1'b1));
      if (k == 1)
        chk("n_lat", 64'(n_ovalid), 64'(1'b0));
      if (k >= 2) begin
        chk("n_vld", 64'(n_ovalid), 64'(1'b1));
        chk("n_or", 64'(n_odata), 64'(ne[k-2]));
      end
    end
    n_valid = 1'b0;

    // Wide op table
    send_one("and",  3'b000, OPS, 8'h00, 1'b0);
    send_one("or",   3'b001, OPS, 8'hFF, 1'b0);
    send_one("xor",  3'b010, OPS, 8'h3C, 1'b0);
    send_one("nand", 3'b011, OPS, 8'hFF, 1'b0);
    send_one("nor",  3'b100, OPS, 8'h00, 1'b0);
    send_one("xnor", 3'b101, OPS, 8'hC3, 1'b0);
    send_one("pass", 3'b110, OPS, 8'hF0, 1'b0);
    send_one("rsv",  3'b111, OPS, 8'h00, 1'b1);
    send_one("and2", 3'b000, OPS, 8'h00, 1'b0);
    send_one("pass7", 3'b110, 32'h1234_5607,
             8'h07, 1'b0);

    // Backpressure: 3 inputs, out_ready low for 4 cycles
    idx = 0;
    ndr = 0;
    in_op = 3'b110;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 4);
      in_valid  = (idx < 3);
      in_data   = bp_in[idx < 3 ? idx : 2];
      @(negedge clk);
      if (c == 2 || c == 3) begin
        chk("bp_stall_rdy", 64'(in_ready), 64'(1'b0));
        chk("bp_hold_vld", 64'(out_valid), 64'(1'b1));
        chk("bp_hold_data", 64'(out_data), 64'(8'h11));
      end
      if (c == 3)
        chk("bp_accepts", 64'(idx), 64'(2));
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        chk("bp_order", 64'(out_data),
            64'(bp_exp[ndr < 3 ? ndr : 2]));
        ndr++;
      end
    end
    in_valid = 1'b0;
    chk("bp_drained", 64'(ndr), 64'(3));
    chk("bp_idle", 64'(out_valid), 64'(1'b0));

    // Reset with both stages full
    out_ready = 1'b0;
    in_op = 3'b001;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 32'h0000_00A5;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mf_full_rdy", 64'(in_ready), 64'(1'b0));
    chk("mf_full_vld", 64'(out_valid), 64'(1'b1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mf_vld", 64'(out_valid), 64'(1'b0));
    chk("mf_data", 64'(out_data), 64'(8'h00));
    chk("mf_rdy", 64'(in_ready), 64'(1'b1));
    ndr = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) ndr++;
    end
    chk("mf_dropped", 64'(ndr), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
